portram_pipe: RTL and testbench

- Parametrised two-read/two-write-port synchronous RAM; next generation of the team's 32x256 dual-port RAM.
- Adds byte-enable writes, configurable read latency with valid strobes, and a defined write-collision policy.
- Adds read-during-write forwarding and a saturating collision counter.
- Used as the shared register/scratch store between two datapath masters.

---
 rtl/portram_pkg.sv | 23 ++
 rtl/portram_rd_pipe.sv | 53 +++++
 rtl/portram_pipe.sv | 153 +++++++++++++++
 tb/tb_portram_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/portram_pkg.sv
// Shared definitions for the two-read/two-write-port RAM: write priority
// encodings, per-byte forwarding source and the byte-enable merge helper.
package portram_pkg;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  // Where one byte of a forwarded read word comes from.
  typedef enum logic [1:0] {
    FWD_OLD = 2'd0,
    FWD_A   = 2'd1,
    FWD_B   = 2'd2
  } fwd_src_e;

  function automatic logic [7:0] be_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/portram_rd_pipe.sv
// Read-return pipeline for one port: one or two register stages carrying the
// issue-edge data word and its valid strobe.
module portram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] data_q,
  output logic              valid_q
);

  generate
    if (RD_LAT >= 2) begin : g_two
      logic [DATA_W-1:0] s1_data_reg;
      logic              s1_valid_reg;

      // The word is frozen in stage 1, so later writes cannot disturb it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_data_reg  <= '0;
          s1_valid_reg <= 1'b0;
          data_q       <= '0;
          valid_q      <= 1'b0;
        end else begin
          s1_valid_reg <= req;
          if (req) begin
            s1_data_reg <= data;
          end
          valid_q <= s1_valid_reg;
          if (s1_valid_reg) begin
            data_q <= s1_data_reg;
          end
        end
      end
    end else begin : g_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= req;
          if (req) begin
            data_q <= data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/portram_pipe.sv
// Two-read/two-write-port RAM with byte enables, write-collision resolution,
// optional read-during-write forwarding and a saturating collision counter.
module portram_pipe
  import portram_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int RD_LAT  = 1,
  parameter int WR_PRIO = 0,
  parameter int BYPASS  = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en_a,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic                rd_valid_a,
  input  logic                rd_en_b,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [DATA_W-1:0]   rd_data_b,
  output logic                rd_valid_b,
  input  logic                wr_en_a,
  input  logic [ADDR_W-1:0]   wr_addr_a,
  input  logic [DATA_W-1:0]   wr_data_a,
  input  logic [DATA_W/8-1:0] wr_be_a,
  input  logic                wr_en_b,
  input  logic [ADDR_W-1:0]   wr_addr_b,
  input  logic [DATA_W-1:0]   wr_data_b,
  input  logic [DATA_W/8-1:0] wr_be_b,
  output logic                collide,
  output logic [CNT_W-1:0]    collide_cnt
);

  localparam int              NB        = DATA_W / 8;
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic            PRIO_SEL  = (WR_PRIO != 0) ? PRIO_B : PRIO_A;
  localparam logic            BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok_a;
  logic              wr_ok_b;
  logic [IDX_W-1:0]  wr_idx_a;
  logic [IDX_W-1:0]  wr_idx_b;
  logic              same_addr;
  logic              collide_next;
  logic [NB-1:0]     be_a_eff;
  logic [NB-1:0]     be_b_eff;
  logic              collide_reg;
  logic [CNT_W-1:0]  collide_cnt_reg;

  assign wr_ok_a  = wr_en_a && ({1'b0, wr_addr_a} < DEPTH_L);
  assign wr_ok_b  = wr_en_b && ({1'b0, wr_addr_b} < DEPTH_L);
  assign wr_idx_a = wr_addr_a[IDX_W-1:0];
  assign wr_idx_b = wr_addr_b[IDX_W-1:0];

  assign same_addr    = wr_ok_a && wr_ok_b && (wr_addr_a == wr_addr_b);
  assign collide_next = same_addr && (|(wr_be_a & wr_be_b));

  // The losing port drops its overlapping bytes, so the two effective
  // enables never overlap on a shared word and the writes merge cleanly.
  assign be_a_eff = wr_ok_a
                  ? (wr_be_a & ~((same_addr && (PRIO_SEL == PRIO_B)) ? wr_be_b : '0))
                  : '0;
  assign be_b_eff = wr_ok_b
                  ? (wr_be_b & ~((same_addr && (PRIO_SEL == PRIO_A)) ? wr_be_a : '0))
                  : '0;

  // Memory contents are not reset; writes are simply suppressed while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collide_reg     <= 1'b0;
      collide_cnt_reg <= '0;
    end else begin
      collide_reg <= collide_next;
      if (collide_next && !(&collide_cnt_reg)) begin
        collide_cnt_reg <= collide_cnt_reg + 1'b1;
      end
      for (int b = 0; b < NB; b++) begin
        if (be_a_eff[b]) begin
          mem[wr_idx_a][b*8 +: 8] <= wr_data_a[b*8 +: 8];
        end
        if (be_b_eff[b]) begin
          mem[wr_idx_b][b*8 +: 8] <= wr_data_b[b*8 +: 8];
        end
      end
    end
  end

  assign collide     = collide_reg;
  assign collide_cnt = collide_cnt_reg;

  logic              rd_en_arr    [2];
  logic [ADDR_W-1:0] rd_addr_arr  [2];
  logic [DATA_W-1:0] rd_data_arr  [2];
  logic              rd_valid_arr [2];

  assign rd_en_arr[0]   = rd_en_a;
  assign rd_en_arr[1]   = rd_en_b;
  assign rd_addr_arr[0] = rd_addr_a;
  assign rd_addr_arr[1] = rd_addr_b;

  genvar gi;
  genvar gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              rd_ok;
      logic              hit_a;
      logic              hit_b;
      logic [DATA_W-1:0] old_word;
      logic [DATA_W-1:0] fwd_word;

      assign rd_ok    = ({1'b0, rd_addr_arr[gi]} < DEPTH_L);
      assign old_word = rd_ok ? mem[rd_addr_arr[gi][IDX_W-1:0]] : '0;
      assign hit_a    = BYPASS_EN && (wr_addr_a == rd_addr_arr[gi]);
      assign hit_b    = BYPASS_EN && (wr_addr_b == rd_addr_arr[gi]);

      // Per byte: take whichever port actually lands on this byte this edge.
      for (gj = 0; gj < NB; gj++) begin : g_byte
        fwd_src_e src;

        assign src = (hit_a && be_a_eff[gj]) ? FWD_A :
                     ((hit_b && be_b_eff[gj]) ? FWD_B : FWD_OLD);
        assign fwd_word[gj*8 +: 8] = be_merge(
          old_word[gj*8 +: 8],
          (src == FWD_A) ? wr_data_a[gj*8 +: 8] : wr_data_b[gj*8 +: 8],
          src != FWD_OLD
        );
      end

      portram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
      ) u_rd_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_en_arr[gi]),
        .data    (fwd_word),
        .data_q  (rd_data_arr[gi]),
        .valid_q (rd_valid_arr[gi])
      );
    end
  endgenerate

  assign rd_data_a  = rd_data_arr[0];
  assign rd_valid_a = rd_valid_arr[0];
  assign rd_data_b  = rd_data_arr[1];
  assign rd_valid_b = rd_valid_arr[1];

endmodule

// File: tb/tb_portram_pipe.sv
// Scoreboard bench: two RAM configurations share one stimulus stream and are
// checked against a word-level behavioural memory model.
module tb_portram_pipe;

  typedef struct packed {
    logic [31:0] due;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        rd_en    [2];
  logic [7:0]  rd_addr  [2];
  logic        wr_en    [2];
  logic [7:0]  wr_addr  [2];
  logic [31:0] wr_data  [2];
  logic [3:0]  wr_be    [2];
  logic [31:0] rd_data  [2][2];
  logic        rd_valid [2][2];
  logic        collide  [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  logic [31:0] mdl      [2][256];
  exp_t        sb       [2][2][$];
  logic [31:0] last     [2][2];
  logic        col_nx   [2];
  logic        col_exp  [2];
  int          cnt_exp  [2];
  int          edge_cnt = 0;
  int          checks   = 0;
  int          errors   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // dut0: defaults. dut1: short depth, two-cycle reads, B priority, no bypass, 2-bit counter.
  portram_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LAT(1),
                 .WR_PRIO(0), .BYPASS(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rd_en_a(rd_en[0]), .rd_addr_a(rd_addr[0]), .rd_data_a(rd_data[0][0]), .rd_valid_a(rd_valid[0][0]),
    .rd_en_b(rd_en[1]), .rd_addr_b(rd_addr[1]), .rd_data_b(rd_data[0][1]), .rd_valid_b(rd_valid[0][1]),
    .wr_en_a(wr_en[0]), .wr_addr_a(wr_addr[0]), .wr_data_a(wr_data[0]), .wr_be_a(wr_be[0]),
    .wr_en_b(wr_en[1]), .wr_addr_b(wr_addr[1]), .wr_data_b(wr_data[1]), .wr_be_b(wr_be[1]),
    .collide(collide[0]), .collide_cnt(cnt0)
  );

  portram_pipe #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LAT(2),
                 .WR_PRIO(1), .BYPASS(0), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_en_a(rd_en[0]), .rd_addr_a(rd_addr[0]), .rd_data_a(rd_data[1][0]), .rd_valid_a(rd_valid[1][0]),
    .rd_en_b(rd_en[1]), .rd_addr_b(rd_addr[1]), .rd_data_b(rd_data[1][1]), .rd_valid_b(rd_valid[1][1]),
    .wr_en_a(wr_en[0]), .wr_addr_a(wr_addr[0]), .wr_data_a(wr_data[0]), .wr_be_a(wr_be[0]),
    .wr_en_b(wr_en[1]), .wr_addr_b(wr_addr[1]), .wr_data_b(wr_data[1]), .wr_be_b(wr_be[1]),
    .collide(collide[1]), .collide_cnt(cnt1)
  );

  function automatic int lat(int d);    return (d == 0) ? 1 : 2;      endfunction
  function automatic int depth(int d);  return (d == 0) ? 256 : 200;  endfunction
  function automatic int prio(int d);   return (d == 0) ? 0 : 1;      endfunction
  function automatic int bypass(int d); return (d == 0) ? 1 : 0;      endfunction
  function automatic int cmax(int d);   return (d == 0) ? 65535 : 3;  endfunction

  function automatic logic [31:0] cnt_of(int d);
    return (d == 0) ? {16'b0, cnt0} : {30'b0, cnt1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      rd_en[p]   = 1'b0;
      rd_addr[p] = 8'h00;
      wr_en[p]   = 1'b0;
      wr_addr[p] = 8'h00;
      wr_data[p] = 32'h0;
      wr_be[p]   = 4'h0;
    end
  endtask

  task automatic set_wr(int p, int a, logic [31:0] d, logic [3:0] be);
    wr_en[p]   = 1'b1;
    wr_addr[p] = 8'(a);
    wr_data[p] = d;
    wr_be[p]   = be;
  endtask

  task automatic set_rd(int p, int a);
    rd_en[p]   = 1'b1;
    rd_addr[p] = 8'(a);
  endtask

  // Model one clock edge: the priority port's bytes are applied last so they
  // win any overlap; a read sees the word before or after that per bypass.
  task automatic tick();
    logic [31:0] pre [2][2];
    exp_t        e;
    int          w;
    for (int d = 0; d < 2; d++) begin
      col_nx[d] = 1'b0;
      if (rst_n) begin
        for (int p = 0; p < 2; p++)
          pre[d][p] = (int'(rd_addr[p]) < depth(d)) ? mdl[d][rd_addr[p]] : 32'h0;
        for (int k = 0; k < 2; k++) begin
          w = (k == 0) ? 1 - prio(d) : prio(d);
          if (wr_en[w] && int'(wr_addr[w]) < depth(d))
            for (int i = 0; i < 4; i++)
              if (wr_be[w][i]) mdl[d][wr_addr[w]][i*8 +: 8] = wr_data[w][i*8 +: 8];
        end
        for (int p = 0; p < 2; p++) begin
          if (rd_en[p]) begin
            e.due = 32'(edge_cnt + lat(d));
            if (int'(rd_addr[p]) >= depth(d)) e.data = 32'h0;
            else if (bypass(d) != 0)          e.data = mdl[d][rd_addr[p]];
            else                              e.data = pre[d][p];
            sb[d][p].push_back(e);
          end
        end
        col_nx[d] = wr_en[0] && wr_en[1] && int'(wr_addr[0]) < depth(d)
                    && wr_addr[0] == wr_addr[1] && (wr_be[0] & wr_be[1]) != 4'h0;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      col_exp[d] = col_nx[d];
      if (col_exp[d] && cnt_exp[d] < cmax(d)) cnt_exp[d]++;
    end
    #1;
  endtask

  task automatic check_all_zero(string tag);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        check($sformatf("%s rd_valid d%0d p%0d", tag, d, p), {31'b0, rd_valid[d][p]}, 32'h0);
        check($sformatf("%s rd_data d%0d p%0d", tag, d, p), rd_data[d][p], 32'h0);
      end
      check($sformatf("%s collide d%0d", tag, d), {31'b0, collide[d]}, 32'h0);
      check($sformatf("%s collide_cnt d%0d", tag, d), cnt_of(d), 32'h0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a valid appears and checks timing,
  // data, hold behaviour and the collision outputs every cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          for (int p = 0; p < 2; p++) begin
            while (sb[d][p].size() > 0 && int'(sb[d][p][0].due) < edge_cnt) begin
              e = sb[d][p].pop_front();
              checks++;
              errors++;
              $display("FAIL rd_valid d%0d p%0d: got no valid, required one at edge %0d (data %h)",
                       d, p, e.due, e.data);
            end
            if (rd_valid[d][p]) begin
              if (sb[d][p].size() == 0 || int'(sb[d][p][0].due) != edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL rd_valid d%0d p%0d: got valid at edge %0d, required none",
                         d, p, edge_cnt);
              end else begin
                e = sb[d][p].pop_front();
                check($sformatf("rd_data d%0d p%0d", d, p), rd_data[d][p], e.data);
                last[d][p] = e.data;
                $display("read dut%0d port%0d edge %0d data %h expected %h",
                         d, p, edge_cnt, rd_data[d][p], e.data);
              end
            end else begin
              check($sformatf("rd_data hold d%0d p%0d", d, p), rd_data[d][p], last[d][p]);
            end
          end
          check($sformatf("collide d%0d", d), {31'b0, collide[d]}, {31'b0, col_exp[d]});
          check($sformatf("collide_cnt d%0d", d), cnt_of(d), 32'(cnt_exp[d]));
        end
      end
    end
  end

  function automatic int rand_addr();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(190, 255)) : int'($urandom_range(0, 15));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    for (int d = 0; d < 2; d++) begin
      col_nx[d]  = 1'b0;
      col_exp[d] = 1'b0;
      cnt_exp[d] = 0;
      for (int p = 0; p < 2; p++) last[d][p] = 32'h0;
    end
    set_wr(0, 1, 32'hDEADBEEF, 4'hF);
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    idle();
    rst_n = 1'b1;

    // Give every word a known value.
    for (int a = 0; a < 256; a += 2) begin
      idle();
      set_wr(0, a, $urandom, 4'hF);
      set_wr(1, a + 1, $urandom, 4'hF);
      tick();
    end

    idle(); set_wr(0, 1, 32'hA5A5A5A5, 4'hF); tick();
    idle(); set_rd(0, 1); tick();
    idle(); tick();

    idle(); set_wr(0, 2, 32'h11223344, 4'hF); tick();
    idle(); set_wr(1, 2, 32'hAABBCCDD, 4'b0101); tick();
    idle(); set_rd(0, 2); set_rd(1, 2); tick();
    idle(); tick();

    idle(); set_wr(0, 5, 32'hAAAAAAAA, 4'hF); set_wr(1, 5, 32'hBBBBBBBB, 4'hF); tick();
    idle(); set_rd(0, 5); tick();
    idle(); set_wr(0, 5, 32'hAAAAAAAA, 4'b0011); set_wr(1, 5, 32'hBBBBBBBB, 4'b1111); tick();
    idle(); set_rd(1, 5); tick();
    idle(); set_wr(0, 6, 32'h0000FFFF, 4'b0011); set_wr(1, 6, 32'hFFFF0000, 4'b1100); tick();
    idle(); set_rd(0, 6); tick();

    idle(); set_wr(0, 7, 32'h0, 4'hF); tick();
    idle(); set_wr(0, 7, 32'h12345678, 4'hF); set_rd(0, 7); set_rd(1, 7); tick();
    idle(); set_wr(1, 7, 32'h0BADF00D, 4'hF); tick();
    idle(); tick(); tick();

    idle(); set_rd(0, 210); set_rd(1, 255); set_wr(1, 220, 32'hCAFEF00D, 4'hF); set_wr(0, 9, 32'h0, 4'h0); tick();
    idle(); set_rd(0, 220); set_rd(1, 9); tick();
    idle(); tick(); tick();

    // Reset with reads in flight and a write held throughout.
    idle(); set_rd(0, 1); set_rd(1, 1); tick();
    idle();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset mid-read");
    for (int d = 0; d < 2; d++) begin
      col_exp[d] = 1'b0;
      cnt_exp[d] = 0;
      for (int p = 0; p < 2; p++) begin
        sb[d][p].delete();
        last[d][p] = 32'h0;
      end
    end
    set_wr(0, 1, 32'h0, 4'hF);
    tick(); tick();
    check_all_zero("reset held");
    rst_n = 1'b1;
    idle(); tick();
    set_rd(0, 1); tick();
    idle(); set_rd(1, 1); tick();
    idle(); tick(); tick();

    repeat (400) begin
      for (int p = 0; p < 2; p++) begin
        rd_en[p]   = ($urandom_range(0, 1) != 0);
        rd_addr[p] = 8'(rand_addr());
        wr_en[p]   = ($urandom_range(0, 3) != 0);
        wr_addr[p] = 8'(rand_addr());
        wr_data[p] = $urandom;
        wr_be[p]   = 4'($urandom);
      end
      if ($urandom_range(0, 2) == 0) wr_addr[1] = wr_addr[0];
      if ($urandom_range(0, 3) == 0) rd_addr[$urandom_range(0, 1)] = wr_addr[0];
      tick();
    end

    idle();
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (sb[d][p].size() != 0) begin
          errors++;
          $display("FAIL drain d%0d p%0d: got %0d reads outstanding, required 0", d, p, sb[d][p].size());
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
